div_share_sched: RTL and testbench
==================================

Name: div_share_sched

Overview:
Shares one iterative fixed-point divider between NREQ requesters, such as the theta2 (acos argument) and theta1 (asin argument) divisions of the inverse-kinematics path.
- Arbitrates round-robin and captures operands on a valid/ready handshake.
- Sequences a restoring magnitude divider bit by bit.
- Returns a signed quotient with overflow flag on a per-requester one-cycle response strobe.
- Replaces per-division free-running dividers with one deterministic-latency shared unit.

Parameters:
N, 32, total word width (sign-magnitude: bit N-1 sign, bits N-2:0 magnitude)
Q, 15, fractional bits
NREQ, 2, number of requesters (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request
req_dividend  in  NREQ*N  dividend of requester i at bits [i*N +: N]
req_divisor  in  NREQ*N  divisor of requester i at bits [i*N +: N]
req_ready  out  NREQ  one-hot grant; handshake = req_valid[i] & req_ready[i] at rising edge
rsp_valid  out  NREQ  one-hot, one-cycle result strobe to the owning requester
rsp_quotient  out  N  result, held until next DONE
rsp_overflow  out  1  overflow / divide-by-zero flag, held with rsp_quotient
busy  out  1  high in ITER and DONE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; rsp_valid=0; rsp_quotient=0; rsp_overflow=0; busy=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has highest priority first.
  - An in-flight operation is discarded; no rsp_valid is ever issued for it.
- States: IDLE -> ITER -> DONE -> IDLE. No other transitions; nothing aborts ITER except reset.
- IDLE:
  - req_ready (combinational) = one-hot of the first valid requester searching last+1, last+2, ... modulo NREQ. It is zero if no request is valid.
  - On handshake by requester g: latch g, sa=dividend[N-1], sb=divisor[N-1], |a|, |b|; set last=g.
  - Working dividend = |a|<<Q (N-1+Q bits); iteration count = N-2+Q; go to ITER.
- ITER:
  - Lasts exactly N-1+Q cycles (46 at defaults). Each cycle produces one quotient bit, MSB first, by restoring compare/subtract of the aligned divisor.
  - req_ready=0 for all requesters.
  - Leaves for DONE when count==0.
- DONE (one cycle):
  - rsp_valid[g]=1.
  - Quotient magnitude qm (N-1+Q bits). Overflow if qm[N-2+Q:N-1]!=0 or |b|==0.
  - On overflow, magnitude saturates to all ones; otherwise magnitude = qm[N-2:0] (truncation, no rounding).
  - Sign = sa^sb, also on overflow; negative zero is permitted.
  - Next state IDLE.
- Latency: handshake at edge ending cycle t -> ITER cycles t+1..t+N-1+Q -> rsp_valid during cycle t+N+Q (t+47 at defaults).
  - Earliest next handshake is cycle t+N+Q+1, so back-to-back operations are spaced N+Q+1 cycles (48).
- Requester rules:
  - Operands must be stable while req_valid is high and unserviced.
  - Dropping req_valid before ready is legal; no grant is issued.
- Divide by zero runs the full ITER length, so latency is data-independent.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep valid and are served in rotation order; no starvation, each waits at most NREQ-1 operations.

Decomposition:
- Shared package div_share_pkg holds:
  - State enum {IDLE, ITER, DONE}.
  - Constants DIV_ITERS = N-1+Q and MAG_W = N-1.
  - Count width = $clog2(N+Q).
- Natural sub-module div_mag_step: restoring magnitude divider datapath.
  - Load port: |a|<<Q, |b| aligned to the top.
  - Step port: one compare/subtract/shift per cycle.
  - Output: qm.
- div_share_sched owns the FSM, arbiter, operand capture, sign/overflow formatting and response.

Test Plan:
1. Req0 6.0/3.0 (0x00030000 / 0x00018000), handshake at t -> rsp_valid[0] only at t+47, rsp_quotient=0x00010000, rsp_overflow=0, busy high t+1..t+47.
2. Req1 -3.0/1.0 (0x80018000 / 0x00008000) -> rsp_valid[1], quotient 0x80018000; then 1.0/3.0 (0x00008000 / 0x00018000) -> 0x00002AAA (truncated).
3. Divide by zero 0x00008000/0x00000000 -> quotient 0x7FFFFFFF, overflow=1, still at t+47; overflow case 0x40000000/0x00000001 -> 0x7FFFFFFF, overflow=1.
4. Req0 and req1 held valid continuously after reset -> grants 0,1,0,1 with req_ready pulses exactly 48 cycles apart; req_ready is never high in ITER/DONE.
5. rst_n low during ITER cycle 20 -> outputs zero immediately, no rsp_valid; after release with both valid, the first IDLE cycle grants req0.
6. req_valid[0] raised for one IDLE cycle then dropped before a grant (req1 busy) -> no grant to req0, no response to req0.

Source files
------------

// File: rtl/div_share_pkg.sv
// div_share_pkg: shared constants and state encoding for the shared fixed-point divider.
// Rev 1.0
`default_nettype none
package div_share_pkg;
    localparam int N_DEF     = 32;
    localparam int Q_DEF     = 15;
    localparam int DIV_ITERS = N_DEF - 1 + Q_DEF;
    localparam int MAG_W     = N_DEF - 1;
    localparam int CNT_W     = $clog2(N_DEF + Q_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage
`default_nettype wire

// File: rtl/div_mag_step.sv
// div_mag_step: restoring magnitude divider, one quotient bit per step, MSB first.
// Rev 1.0
`default_nettype none
module div_mag_step #(
    parameter int MAG_W  = 31,
    parameter int WORK_W = 46
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [WORK_W-1:0] dividend_i,
    input  logic [MAG_W-1:0]  divisor_i,
    output logic [WORK_W-1:0] qm_o
);
    logic [MAG_W-1:0]  rem_q, rem_d;
    logic [WORK_W-1:0] quo_q, quo_d;
    logic [MAG_W-1:0]  dvs_q;
    logic [MAG_W:0]    w_shift;
    logic [MAG_W:0]    w_diff;
    logic              w_fit;

    // The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
    assign w_shift = {rem_q, quo_q[WORK_W-1]};
    assign w_fit   = (w_shift >= {1'b0, dvs_q});
    assign w_diff  = w_shift - {1'b0, dvs_q};

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        if (step_i) begin
            rem_d = w_fit ? w_diff[MAG_W-1:0] : w_shift[MAG_W-1:0];
            quo_d = {quo_q[WORK_W-2:0], w_fit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign qm_o = quo_q;
endmodule
`default_nettype wire

// File: rtl/div_share_sched.sv
// div_share_sched: round-robin shared sign-magnitude fixed-point divider with fixed latency.
// Rev 1.0
`default_nettype none
module div_share_sched
    import div_share_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int Q    = Q_DEF,
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_dividend,
    input  logic [NREQ*N-1:0] req_divisor,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      rsp_quotient,
    output logic              rsp_overflow,
    output logic              busy
);
    localparam int MW = N - 1;
    localparam int WW = N - 1 + Q;
    localparam int CW = $clog2(N + Q);
    localparam int IW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            sign_q, sign_d;
    logic            bzero_q, bzero_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    quot_q, quot_d;
    logic            ovf_q, ovf_d;

    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_gidx;
    logic [IW-1:0]   w_cand;
    logic            w_found;
    logic [N-1:0]    w_sel_a, w_sel_b;
    logic            w_hs;
    logic [WW-1:0]   w_qm;
    logic            w_ovf;
    logic [N-1:0]    w_quot;

    // Search starts one past the last winner, so every waiting requester is reached in rotation.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IW'((int'(last_q) + k) % NREQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found         = 1'b1;
                w_grant[w_cand] = 1'b1;
                w_gidx          = w_cand;
            end
        end
    end

    assign req_ready = (state_q == IDLE) ? w_grant : '0;
    assign w_hs      = |(req_valid & req_ready);
    assign w_sel_a   = req_dividend[int'(w_gidx)*N +: N];
    assign w_sel_b   = req_divisor[int'(w_gidx)*N +: N];

    div_mag_step #(
        .MAG_W  (MW),
        .WORK_W (WW)
    ) u_mag (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_hs),
        .step_i     (state_q == ITER),
        .dividend_i ({w_sel_a[MW-1:0], {Q{1'b0}}}),
        .divisor_i  (w_sel_b[MW-1:0]),
        .qm_o       (w_qm)
    );

    // Any set bit above the magnitude field cannot be represented, so the result saturates.
    assign w_ovf  = (w_qm[WW-1:MW] != '0) || bzero_q;
    assign w_quot = {sign_q, w_ovf ? {MW{1'b1}} : w_qm[MW-1:0]};

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        sign_d  = sign_q;
        bzero_d = bzero_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (w_hs) begin
                    owner_d = w_gidx;
                    last_d  = w_gidx;
                    sign_d  = w_sel_a[N-1] ^ w_sel_b[N-1];
                    bzero_d = (w_sel_b[MW-1:0] == '0);
                    cnt_d   = CW'(WW - 1);
                    state_d = ITER;
                end
            end
            ITER: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE: begin
                quot_d  = w_quot;
                ovf_d   = w_ovf;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IW'(NREQ - 1);
            owner_q <= '0;
            sign_q  <= 1'b0;
            bzero_q <= 1'b0;
            cnt_q   <= '0;
            quot_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            sign_q  <= sign_d;
            bzero_q <= bzero_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rsp_valid    = (state_q == DONE) ? (NREQ'(1) << owner_q) : '0;
    assign rsp_quotient = (state_q == DONE) ? w_quot : quot_q;
    assign rsp_overflow = (state_q == DONE) ? w_ovf : ovf_q;
    assign busy         = (state_q != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_div_share_sched.sv
// tb_div_share_sched: directed self-checking bench for div_share_sched.
// Rev 1.0
`default_nettype none
module tb_div_share_sched;
    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [63:0] req_dividend;
    logic [63:0] req_divisor;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_quotient;
    logic        rsp_overflow;
    logic        busy;

    int total = 0;
    int bad   = 0;

    div_share_sched #(.N(32), .Q(15), .NREQ(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_quotient (rsp_quotient),
        .rsp_overflow (rsp_overflow),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation for requester r; checks grant, ITER quietness, t+47 response and hold.
    task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic exp_o, input string tag);
        int  n;
        bit  ok;
        req_dividend[r*32 +: 32] = a;
        req_divisor[r*32 +: 32]  = b;
        req_valid[r]             = 1'b1;
        n = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_grant"}, req_ready, 64'(2'b01 << r));
        @(posedge clk);
        #1 req_valid[r] = 1'b0;
        ok = 1'b1;
        for (int c = 1; c <= 46; c++) begin
            @(negedge clk);
            if (!(busy === 1'b1 && rsp_valid === 2'b00 && req_ready === 2'b00)) ok = 1'b0;
        end
        chk({tag, "_iter"}, ok, 1);
        @(negedge clk);
        chk({tag, "_rspv"}, rsp_valid, 64'(2'b01 << r));
        chk({tag, "_quot"}, rsp_quotient, exp_q);
        chk({tag, "_ovf"}, rsp_overflow, exp_o);
        chk({tag, "_busy_done"}, busy, 1);
        @(negedge clk);
        chk({tag, "_idle"}, {busy, rsp_valid}, 0);
        chk({tag, "_hold"}, {rsp_overflow, rsp_quotient}, {exp_o, exp_q});
    endtask

    initial begin
        int  n;
        bit  ok;
        bit  seen1;
        int  gcnt;
        int  gt[4];
        logic [1:0] gv[4];

        rst_n        = 1'b0;
        req_valid    = 2'b00;
        req_dividend = '0;
        req_divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_out", {rsp_valid, rsp_quotient, rsp_overflow, busy, req_ready}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(0, 32'h0003_0000, 32'h0001_8000, 32'h0001_0000, 1'b0, "t1_6div3");
        do_op(1, 32'h8001_8000, 32'h0000_8000, 32'h8001_8000, 1'b0, "t2_neg3div1");
        do_op(1, 32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0, "t2_1div3");
        do_op(0, 32'h0000_8000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, "t3_div0");
        do_op(1, 32'h4000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, "t3_ovf");

        // Requester 0 pulses valid only while requester 1 is being served.
        req_dividend[32 +: 32] = 32'h0000_8000;
        req_divisor[32 +: 32]  = 32'h0001_8000;
        req_dividend[0 +: 32]  = 32'h0003_0000;
        req_divisor[0 +: 32]   = 32'h0001_8000;
        req_valid[1] = 1'b1;
        n = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_grant1", req_ready, 2'b10);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        repeat (5) @(negedge clk);
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        ok = 1'b1;
        seen1 = 1'b0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b0) ok = 1'b0;
            if (rsp_valid[1] === 1'b1) seen1 = 1'b1;
        end
        chk("t6_no_req0", ok, 1);
        chk("t6_rsp1_seen", seen1, 1);
        chk("t6_quot", rsp_quotient, 32'h0000_2AAA);

        // Both requesters held valid from a fresh reset: rotation and spacing.
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        ok = 1'b1;
        gcnt = 0;
        for (int i = 0; i < 4; i++) begin
            gt[i] = 0;
            gv[i] = 2'b00;
        end
        for (int c = 0; c < 200; c++) begin
            if (req_ready !== 2'b00) begin
                if (busy !== 1'b0) ok = 1'b0;
                if (gcnt < 4) begin
                    gt[gcnt] = c;
                    gv[gcnt] = req_ready;
                end
                gcnt++;
            end
            @(negedge clk);
            #1;
        end
        chk("t4_g0", gv[0], 2'b01);
        chk("t4_g1", gv[1], 2'b10);
        chk("t4_g2", gv[2], 2'b01);
        chk("t4_g3", gv[3], 2'b10);
        chk("t4_first_cycle", gt[0], 0);
        chk("t4_gap01", gt[1] - gt[0], 48);
        chk("t4_gap12", gt[2] - gt[1], 48);
        chk("t4_gap23", gt[3] - gt[2], 48);
        chk("t4_ready_idle_only", ok, 1);

        // Reset in the middle of ITER discards the operation.
        n = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_pre_grant", req_ready !== 2'b00, 1);
        @(posedge clk);
        repeat (20) @(negedge clk);
        chk("t5_in_iter", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_out", {rsp_valid, rsp_quotient, rsp_overflow, busy}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t5_first_grant", req_ready, 2'b01);
        req_valid = 2'b00;
        ok = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (rsp_valid !== 2'b00 || busy !== 1'b0) ok = 1'b0;
        end
        chk("t5_no_rsp", ok, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
